// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg
//   Shared types and constants for the vector load/store sequencer.
//   - seqState_t : sequencer FSM states
//   - BEATS, WORD_BYTES, ALIGN_BITS : geometry of the default 128-bit
//     vector over a 32-bit data-memory port
//   - beatsOf / alignBitsOf / cntWidth : the same geometry derived from
//     arbitrary widths, so modules stay consistent with their parameters
package vec_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seqState_t;

  localparam int VEC_W_DEF  = 128;
  localparam int WORD_W_DEF = 32;
  localparam int BEATS      = VEC_W_DEF / WORD_W_DEF;
  localparam int WORD_BYTES = WORD_W_DEF / 8;
  localparam int ALIGN_BITS = $clog2(VEC_W_DEF / 8);

  function automatic int beatsOf(input int vecW, input int wordW);
    return vecW / wordW;
  endfunction

  function automatic int alignBitsOf(input int vecW);
    return $clog2(vecW / 8);
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_beat_buffer.sv
// vec_beat_buffer
//   VEC_W-bit assembly register for vector loads, written one word lane
//   at a time.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset (clears buffer)
//     clear           synchronous clear of every lane
//     wrEn            write lane wrIdx with wrData this cycle
//     wrIdx, wrData   lane index (lane 0 = least significant) and word
//     data            current buffer contents
//     merged          contents as they will be after this cycle's write,
//                     so the caller can capture the completed vector on
//                     the same edge that writes the final lane
module vec_beat_buffer
  import vec_mem_pkg::*;
#(
  parameter int VEC_W  = 128,
  parameter int WORD_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear,
  input  logic                                    wrEn,
  input  logic [cntWidth(VEC_W / WORD_W)-1:0]     wrIdx,
  input  logic [WORD_W-1:0]                       wrData,
  output logic [VEC_W-1:0]                        data,
  output logic [VEC_W-1:0]                        merged
);

  localparam int NWORDS = beatsOf(VEC_W, WORD_W);
  localparam int IDX_W  = cntWidth(NWORDS);

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_lane
      logic [WORD_W-1:0] wordReg;
      logic              hit;

      assign hit = wrEn && (wrIdx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wordReg <= '0;
        end else if (clear) begin
          wordReg <= '0;
        end else if (hit) begin
          wordReg <= wrData;
        end
      end

      assign data[gi*WORD_W +: WORD_W]   = wordReg;
      assign merged[gi*WORD_W +: WORD_W] = hit ? wrData : wordReg;
    end
  endgenerate

endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//   MEM-stage sequencer that splits one VEC_W-bit vector load/store into
//   VEC_W/WORD_W word beats on the scalar data-memory port, stalling the
//   pipeline while the beats run and assembling load beats into a vector
//   for the vector register-file write.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start_i             vector memory op valid (held while stall_o=1)
//     is_store_i          1 = store, 0 = load
//     base_addr_i         byte base address (must be VEC_W/8 aligned)
//     store_data_i        vector store data
//     dest_reg_i          destination vector register for loads
//     stall_o             freeze IF/ID/EX/MEM
//     done_o, misalign_o  one-cycle completion pulse / misaligned flag
//     wb_en_o, wb_reg_o   vector register write enable and index
//     load_data_o         assembled load vector (held until next load)
//     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o   beat request
//     mem_gnt_i           beat accepted this cycle
//     mem_rvalid_i, mem_rdata_i   read response (>=1 cycle after gnt)
module vector_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int VEC_W  = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              is_store_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [VEC_W-1:0]  store_data_i,
  input  logic [4:0]        dest_reg_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_reg_o,
  output logic [VEC_W-1:0]  load_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  localparam int NBEATS = beatsOf(VEC_W, WORD_W);
  localparam int NBYTES = WORD_W / 8;
  localparam int NALIGN = alignBitsOf(VEC_W);
  localparam int CNT_W  = cntWidth(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  seqState_t          stateReg, stateNext;
  logic [CNT_W-1:0]   beatReg;
  logic               isStoreReg;
  logic               misalignReg;
  logic [ADDR_W-1:0]  baseReg;
  logic [VEC_W-1:0]   storeDataReg;
  logic [4:0]         destReg;
  logic [4:0]         wbRegOut;
  logic [VEC_W-1:0]   loadOutReg;

  logic               inIdle, inIssue, inWait, inDone;
  logic               accept, misalignIn, lastBeat;
  logic               issueGnt, loadWordWr, beatAdvance;
  logic [ADDR_W-1:0]  beatAddr;
  logic [WORD_W-1:0]  storeWord;
  logic [VEC_W-1:0]   bufData, bufMerged;

  assign inIdle  = (stateReg == IDLE);
  assign inIssue = (stateReg == ISSUE);
  assign inWait  = (stateReg == WAIT);
  assign inDone  = (stateReg == DONE);

  assign accept      = inIdle && start_i;
  assign misalignIn  = (base_addr_i[NALIGN-1:0] != '0);
  assign lastBeat    = (beatReg == LAST_BEAT);
  assign issueGnt    = inIssue && mem_gnt_i;
  assign loadWordWr  = inWait && mem_rvalid_i;
  // A store beat finishes on its grant; a load beat only on its read data.
  assign beatAdvance = ((issueGnt && isStoreReg) || loadWordWr) && !lastBeat;

  // Address arithmetic is truncated to ADDR_W bits, so a base near the top
  // of the address space wraps silently.
  assign beatAddr  = baseReg + (ADDR_W'(beatReg) * ADDR_W'(NBYTES));
  assign storeWord = storeDataReg[WORD_W*beatReg +: WORD_W];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: begin
        if (start_i) begin
          stateNext = misalignIn ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          if (!isStoreReg) begin
            stateNext = WAIT;
          end else if (lastBeat) begin
            stateNext = DONE;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          stateNext = lastBeat ? DONE : ISSUE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beatReg      <= '0;
      isStoreReg   <= 1'b0;
      misalignReg  <= 1'b0;
      baseReg      <= '0;
      storeDataReg <= '0;
      destReg      <= '0;
      wbRegOut     <= '0;
      loadOutReg   <= '0;
    end else begin
      if (accept) begin
        isStoreReg   <= is_store_i;
        misalignReg  <= misalignIn;
        baseReg      <= base_addr_i;
        storeDataReg <= store_data_i;
        destReg      <= dest_reg_i;
        beatReg      <= '0;
      end else if (beatAdvance) begin
        beatReg <= beatReg + 1'b1;
      end else if (inDone) begin
        beatReg <= '0;
      end

      // The visible load vector only changes when a load completes, so a
      // following load's partial beats never leak onto load_data_o.
      if (loadWordWr && lastBeat) begin
        loadOutReg <= bufMerged;
        wbRegOut   <= destReg;
      end
    end
  end

  vec_beat_buffer #(
    .VEC_W  (VEC_W),
    .WORD_W (WORD_W)
  ) u_beatBuffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept && !is_store_i),
    .wrEn   (loadWordWr),
    .wrIdx  (beatReg),
    .wrData (mem_rdata_i),
    .data   (bufData),
    .merged (bufMerged)
  );

  // bufData is kept as the raw assembly view; only the merged view feeds
  // the output register.
  logic bufUnused;
  assign bufUnused = ^bufData;

  // ------------------------------------------------------------ outputs
  // Gating with rst_n keeps stall low during reset even if start_i is
  // still asserted by the frozen pipeline.
  assign stall_o     = rst_n && (accept || inIssue || inWait);
  assign done_o      = inDone;
  assign misalign_o  = inDone && misalignReg;
  assign wb_en_o     = inDone && !isStoreReg && !misalignReg;
  assign wb_reg_o    = wbRegOut;
  assign load_data_o = loadOutReg;

  // Request fields come straight from registered state, so they stay
  // stable for as long as a beat waits for its grant.
  assign mem_req_o   = inIssue;
  assign mem_we_o    = inIssue && isStoreReg;
  assign mem_addr_o  = inIssue ? beatAddr : '0;
  assign mem_wdata_o = (inIssue && isStoreReg) ? storeWord : '0;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;
  import vec_mem_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          is_store_i = 1'b0;
  logic [31:0]   base_addr_i = '0;
  logic [127:0]  store_data_i = '0;
  logic [4:0]    dest_reg_i = '0;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic          stall_o, done_o, misalign_o, wb_en_o;
  logic [4:0]    wb_reg_o;
  logic [127:0]  load_data_o;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;

  always #5 clk = ~clk;

  vector_mem_sequencer #(.VEC_W(128), .WORD_W(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .is_store_i   (is_store_i),
    .base_addr_i  (base_addr_i),
    .store_data_i (store_data_i),
    .dest_reg_i   (dest_reg_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .misalign_o   (misalign_o),
    .wb_en_o      (wb_en_o),
    .wb_reg_o     (wb_reg_o),
    .load_data_o  (load_data_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: word-addressed by byte address.
  logic [31:0]  mem [logic [31:0]];
  logic [127:0] lastLoad = '0;
  logic [4:0]   lastReg = '0;
  bit           spur = 1'b0;
  int           holdTab [BEATS];
  int           delayTab [BEATS];
  int           opNum = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  // Runs one vector op starting at a negedge in IDLE; acts as the memory
  // slave (grant withholding from holdTab, read latency from delayTab).
  task automatic runOp(input bit st, input logic [31:0] base, input logic [127:0] data,
                       input logic [4:0] dest, input bit keepStart, input int abortBeat);
    bit           mis, outst, outstBefore, finished, aborted;
    int           expCyc, kg, holdCnt, rvCnt, cyc;
    logic [127:0] expVec;
    logic [31:0]  expAddr;
    mis = (base[ALIGN_BITS-1:0] != '0);
    expCyc = 2;
    expVec = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (!mis) expCyc += holdTab[k] + 1 + (st ? 0 : delayTab[k]);
      expVec[32*k +: 32] = memRead(base + 32'(WORD_BYTES * k));
    end
    start_i = 1'b1; is_store_i = st; base_addr_i = base;
    store_data_i = data; dest_reg_i = dest;
    kg = 0; holdCnt = holdTab[0]; outst = 1'b0; rvCnt = 0;
    finished = 1'b0; aborted = 1'b0; cyc = 1;
    while (!finished && cyc <= 100) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      outstBefore = outst;
      if (outst && abortBeat >= 0 && kg - 1 == abortBeat) begin
        rst_n = 1'b0;
        #1;
        chk("rst_req", 128'(mem_req_o), 128'(0));
        chk("rst_stall", 128'(stall_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_wben", 128'(wb_en_o), 128'(0));
        chk("rst_loaddata", load_data_o, 128'(0));
        chk("rst_wbreg", 128'(wb_reg_o), 128'(0));
        lastLoad = '0; lastReg = '0;
        finished = 1'b1; aborted = 1'b1;
      end else begin
        if (outst) begin
          rvCnt--;
          if (rvCnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = expVec[32*(kg-1) +: 32];
            outst = 1'b0;
          end
        end else if (spur) begin
          mem_rvalid_i = 1'($urandom_range(0, 1));
        end
        if (mem_req_o) begin
          chk("one_outstanding", 128'(outstBefore), 128'(0));
          if (kg < BEATS) begin
            expAddr = base + 32'(WORD_BYTES * kg);
            chk("beat_addr", 128'(mem_addr_o), 128'(expAddr));
            chk("beat_we", 128'(mem_we_o), 128'(st));
            if (st) chk("beat_wdata", 128'(mem_wdata_o), 128'(data[32*kg +: 32]));
            if (holdCnt > 0) begin
              holdCnt--;
            end else begin
              mem_gnt_i = 1'b1;
              if (st) mem[expAddr] = data[32*kg +: 32];
              else begin outst = 1'b1; rvCnt = delayTab[kg]; end
              kg++;
              if (kg < BEATS) holdCnt = holdTab[kg];
            end
          end else begin
            chk("extra_req", 128'(1), 128'(0));
          end
        end else if (spur) begin
          mem_gnt_i = 1'($urandom_range(0, 1));
        end
        #1;
        if (done_o) begin
          chk("latency", 128'(cyc), 128'(expCyc));
          chk("beats", 128'(kg), 128'(mis ? 0 : BEATS));
          chk("misalign", 128'(misalign_o), 128'(mis));
          chk("wb_en", 128'(wb_en_o), 128'(!st && !mis));
          chk("done_stall", 128'(stall_o), 128'(0));
          if (!st && !mis) begin lastLoad = expVec; lastReg = dest; end
          chk("load_data", load_data_o, lastLoad);
          chk("wb_reg", 128'(wb_reg_o), 128'(lastReg));
          finished = 1'b1;
          if (!keepStart) start_i = 1'b0;
        end else begin
          chk("busy_stall", 128'(stall_o), 128'(1));
          chk("busy_wben", 128'(wb_en_o), 128'(0));
          chk("busy_misalign", 128'(misalign_o), 128'(0));
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished) chk("timeout", 128'(0), 128'(1));
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    if (aborted) begin rst_n = 1'b1; start_i = 1'b0; end
    opNum++;
    $display("op %0d %s base %h dest %0d cycles %0d%s", opNum, st ? "store" : "load",
             base, dest, cyc - 1, aborted ? " aborted by reset" : "");
  endtask

  task automatic setTiming(input int h, input int d);
    for (int k = 0; k < BEATS; k++) begin holdTab[k] = h; delayTab[k] = d; end
  endtask

  task automatic idleCycle();
    #1;
    chk("idle_stall", 128'(stall_o), 128'(0));
    chk("idle_req", 128'(mem_req_o), 128'(0));
    chk("idle_done", 128'(done_o), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    bit           st, mis, keep;
    logic [31:0]  base;
    logic [127:0] data;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_stall", 128'(stall_o), 128'(0));
    chk("reset_req", 128'(mem_req_o), 128'(0));
    chk("reset_done", 128'(done_o), 128'(0));
    chk("reset_wben", 128'(wb_en_o), 128'(0));
    chk("reset_loaddata", load_data_o, 128'(0));
    chk("reset_addr", 128'(mem_addr_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned load, immediate grant, rvalid one cycle later: 10 cycles
    mem[32'h100] = 32'h11111111; mem[32'h104] = 32'h22222222;
    mem[32'h108] = 32'h33333333; mem[32'h10C] = 32'h44444444;
    setTiming(0, 1);
    runOp(1'b0, 32'h100, '0, 5'd5, 1'b0, -1);
    chk("load_vec_const", load_data_o, 128'h44444444_33333333_22222222_11111111);

    // Aligned store, beat 1 grant withheld two cycles
    setTiming(0, 1); holdTab[1] = 2;
    runOp(1'b1, 32'h200, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 5'd9, 1'b0, -1);
    idleCycle();

    // Immediate store latency is 6 cycles
    setTiming(0, 1);
    runOp(1'b1, 32'h240, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 5'd1, 1'b0, -1);

    // Misaligned load: no beats, done+misalign in cycle 2
    runOp(1'b0, 32'h104, '0, 5'd3, 1'b0, -1);

    // Reset during WAIT of beat 2
    setTiming(0, 2);
    runOp(1'b0, 32'h300, '0, 5'd12, 1'b0, 2);
    idleCycle();

    // Back-to-back store then load with start held, spurious responses
    spur = 1'b1;
    setTiming(1, 1);
    runOp(1'b1, 32'h400, 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678, 5'd2, 1'b1, -1);
    runOp(1'b0, 32'h400, '0, 5'd20, 1'b0, -1);
    chk("b2b_readback", load_data_o, 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678);

    // Read back the withheld-grant store
    setTiming(0, 1);
    runOp(1'b0, 32'h200, '0, 5'd31, 1'b0, -1);
    chk("store_readback", load_data_o, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

    // Address wrap at the top of the address space
    runOp(1'b0, 32'hFFFFFFF0, '0, 5'd7, 1'b0, -1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      st   = 1'($urandom_range(0, 1));
      mis  = ($urandom_range(0, 3) == 0);
      base = 32'h1000 + 32'($urandom_range(0, 15) << 4) + (mis ? 32'($urandom_range(1, 15)) : 32'h0);
      data = {$urandom, $urandom, $urandom, $urandom};
      keep = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < BEATS; k++) begin
        holdTab[k]  = $urandom_range(0, 2);
        delayTab[k] = $urandom_range(1, 3);
      end
      runOp(st, base, data, 5'($urandom_range(0, 31)), keep, -1);
      if (!keep) begin
        for (int i = 0; i < $urandom_range(0, 2); i++) idleCycle();
      end
    end
    start_i = 1'b0;
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
